// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with interrupt.
//
// Software programs three word registers through the bridge:
//   Addr 0  CTRL   {.., IM[3], Mode[2:1], Enable[0]}  (write also clears a pending request)
//   Addr 1  PRESET reload value (read/write)
//   Addr 2  COUNT  current count (read-only)
//   Addr 3  reserved, reads 0
// Mode 1 auto-reloads (periodic); every other mode value is one-shot.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   Addr   word offset (bus address [3:2])
//   We     write strobe, commits on the rising edge
//   DIn    write data
//   DOut   read data, combinational from Addr
//   IRQ    interrupt request (IM & irq_flag), driven only from registers
module timer_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Addr,
  input  logic             We,
  input  logic [WIDTH-1:0] DIn,
  output logic [WIDTH-1:0] DOut,
  output logic             IRQ
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic             flag_q, flag_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      flag_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      flag_q   <= flag_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    flag_d   = flag_q;
    preset_d = preset_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: if (en_q) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;          // pause: COUNT frozen
        end else if (count_q == '0) begin
          state_d = S_INT;
          flag_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      S_INT: begin
        if (mode_q == 2'b01) begin
          state_d = S_LOAD;
          flag_d  = 1'b0;            // one-cycle pulse per period
        end else begin
          state_d = S_IDLE;
          en_d    = 1'b0;            // one-shot: flag held until CTRL write
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes are applied last so they win over same-edge FSM updates.
    if (We) begin
      case (Addr)
        A_CTRL: begin
          {im_d, mode_d, en_d} = DIn[3:0];
          flag_d = 1'b0;
        end
        A_PRESET: preset_d = DIn;
        default: ;
      endcase
    end
  end

  always_comb begin
    DOut = '0;
    case (Addr)
      A_CTRL:   DOut[3:0] = {im_q, mode_q, en_q};
      A_PRESET: DOut = preset_q;
      A_COUNT:  DOut = count_q;
      default:  DOut = '0;
    endcase
  end

  assign IRQ = im_q & flag_q;

endmodule
